// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, opcode classes, sequencer states and control strobe bundle.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10001;

    typedef enum logic [1:0] {
        CLS_BIN,
        CLS_UN,
        CLS_WIDE,
        CLS_ILL
    } op_class_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T1W,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_FIN
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    // Map an opcode onto its execution class.
    function automatic op_class_e op_class(input logic [OPC_W-1:0] opc);
        op_class_e cls;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL: cls = CLS_BIN;
            OPC_NEG, OPC_NOT:                    cls = CLS_UN;
            OPC_MUL, OPC_DIV:                    cls = CLS_WIDE;
            default:                             cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Handshake, instruction and control-strobe bundle between the sequencer and its datapath.
interface alu_op_sequencer_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OP_W     = 5
);
    logic                start;
    logic                mem_ready;
    logic [31:0]         ir;

    logic                PCout;
    logic                Zlowout;
    logic                Zhighout;
    logic                MDRout;
    logic                MARin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                Zin;
    logic                HIin;
    logic                LOin;
    logic                IncPC;
    logic                Read;
    logic [OP_W-1:0]     alu_op;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, mem_ready, ir,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read,
        input  alu_op, reg_in, reg_out, busy, done, err
    );

    modport slave (
        input  start, mem_ready, ir,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read,
        output alu_op, reg_in, reg_out, busy, done, err
    );

endinterface

// File: rtl/onehot_decoder.sv
// Register index to one-hot enable; all zero when disabled or index out of range.
module onehot_decoder #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_IDX_W = 4
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot_c
);

    // One compare per register line.
    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot_c[i] = en && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Microcoded fetch/execute control sequencer for the register ALU datapath.
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned OP_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);

    localparam int unsigned RA_MSB    = 31 - OP_W;
    localparam int unsigned RB_MSB    = RA_MSB - REG_IDX_W;
    localparam int unsigned RC_MSB    = RB_MSB - REG_IDX_W;
    localparam int unsigned FIELD_LSB = RC_MSB - REG_IDX_W + 1;

    state_e                state_q, state_nxt;
    logic [OP_W-1:0]       opc_q, opc_nxt;
    logic [REG_IDX_W-1:0]  ra_q, ra_nxt;
    logic [REG_IDX_W-1:0]  rb_q, rb_nxt;
    logic [REG_IDX_W-1:0]  rc_q, rc_nxt;
    op_class_e             cls_cur, cls_nxt;

    ctrl_t                 ctrl_q, ctrl_nxt;
    logic [OP_W-1:0]       alu_op_q, alu_op_nxt;
    logic [NUM_REGS-1:0]   reg_in_q, reg_out_q;
    logic [NUM_REGS-1:0]   reg_in_c, reg_out_c;
    logic                  rin_en, rout_en;
    logic [REG_IDX_W-1:0]  rin_idx, rout_idx;

    logic                  unused_ir_low;
    assign unused_ir_low = ^bus.ir[FIELD_LSB-1:0];

    function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    // Class of an instruction, demoting it to illegal if a used register field is out of range.
    function automatic op_class_e classify(input logic [OP_W-1:0] opc,
                                           input logic [REG_IDX_W-1:0] a,
                                           input logic [REG_IDX_W-1:0] b,
                                           input logic [REG_IDX_W-1:0] c);
        op_class_e cls;
        cls = op_class(OPC_W'(opc));
        case (cls)
            CLS_BIN:         if (!idx_ok(a) || !idx_ok(b) || !idx_ok(c)) cls = CLS_ILL;
            CLS_UN, CLS_WIDE: if (!idx_ok(a) || !idx_ok(b)) cls = CLS_ILL;
            default: ;
        endcase
        return cls;
    endfunction

    assign cls_cur = classify(opc_q, ra_q, rb_q, rc_q);
    assign cls_nxt = classify(opc_nxt, ra_nxt, rb_nxt, rc_nxt);

    // Next state; instruction fields are captured as the sequencer leaves T2.
    always_comb begin
        state_nxt = state_q;
        opc_nxt   = opc_q;
        ra_nxt    = ra_q;
        rb_nxt    = rb_q;
        rc_nxt    = rc_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   state_nxt = bus.mem_ready ? ST_T2 : ST_T1W;
            ST_T1W:  if (bus.mem_ready) state_nxt = ST_T2;
            ST_T2: begin
                state_nxt = ST_T3;
                opc_nxt   = bus.ir[31 -: OP_W];
                ra_nxt    = bus.ir[RA_MSB -: REG_IDX_W];
                rb_nxt    = bus.ir[RB_MSB -: REG_IDX_W];
                rc_nxt    = bus.ir[RC_MSB -: REG_IDX_W];
            end
            ST_T3:   state_nxt = (cls_cur == CLS_ILL) ? ST_IDLE : ST_T4;
            ST_T4:   state_nxt = (cls_cur == CLS_UN) ? ST_FIN : ST_T5;
            ST_T5:   state_nxt = (cls_cur == CLS_WIDE) ? ST_T6 : ST_FIN;
            ST_T6:   state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode of the state being entered, so outputs can be registered.
    always_comb begin
        ctrl_nxt      = '0;
        alu_op_nxt    = '0;
        rin_en        = 1'b0;
        rout_en       = 1'b0;
        rin_idx       = ra_nxt;
        rout_idx      = rb_nxt;
        ctrl_nxt.busy = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_T0: begin
                ctrl_nxt.pc_out = 1'b1;
                ctrl_nxt.mar_in = 1'b1;
                ctrl_nxt.inc_pc = 1'b1;
                ctrl_nxt.z_in   = 1'b1;
            end
            ST_T1: begin
                ctrl_nxt.zlow_out = 1'b1;
                ctrl_nxt.pc_in    = 1'b1;
                ctrl_nxt.read     = 1'b1;
                ctrl_nxt.mdr_in   = 1'b1;
            end
            ST_T1W: begin
                ctrl_nxt.read   = 1'b1;
                ctrl_nxt.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl_nxt.mdr_out = 1'b1;
                ctrl_nxt.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls_nxt)
                    CLS_BIN: begin
                        rout_en       = 1'b1;
                        ctrl_nxt.y_in = 1'b1;
                    end
                    CLS_UN: begin
                        rout_en       = 1'b1;
                        alu_op_nxt    = opc_nxt;
                        ctrl_nxt.z_in = 1'b1;
                    end
                    CLS_WIDE: begin
                        rout_en       = 1'b1;
                        rout_idx      = ra_nxt;
                        ctrl_nxt.y_in = 1'b1;
                    end
                    default: ctrl_nxt.err = 1'b1;
                endcase
            end
            ST_T4: begin
                if (cls_nxt == CLS_UN) begin
                    ctrl_nxt.zlow_out = 1'b1;
                    rin_en            = 1'b1;
                end else begin
                    rout_en       = 1'b1;
                    rout_idx      = (cls_nxt == CLS_BIN) ? rc_nxt : rb_nxt;
                    alu_op_nxt    = opc_nxt;
                    ctrl_nxt.z_in = 1'b1;
                end
            end
            ST_T5: begin
                ctrl_nxt.zlow_out = 1'b1;
                if (cls_nxt == CLS_WIDE) ctrl_nxt.lo_in = 1'b1;
                else                     rin_en         = 1'b1;
            end
            ST_T6: begin
                ctrl_nxt.zhigh_out = 1'b1;
                ctrl_nxt.hi_in     = 1'b1;
            end
            ST_FIN:  ctrl_nxt.done = 1'b1;
            default: ;
        endcase
    end

    onehot_decoder #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_dec_reg_in (
        .idx      (rin_idx),
        .en       (rin_en),
        .onehot_c (reg_in_c)
    );

    onehot_decoder #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_dec_reg_out (
        .idx      (rout_idx),
        .en       (rout_en),
        .onehot_c (reg_out_c)
    );

    // State, latched instruction fields and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            ctrl_q    <= '0;
            alu_op_q  <= '0;
            reg_in_q  <= '0;
            reg_out_q <= '0;
        end else begin
            state_q   <= state_nxt;
            opc_q     <= opc_nxt;
            ra_q      <= ra_nxt;
            rb_q      <= rb_nxt;
            rc_q      <= rc_nxt;
            ctrl_q    <= ctrl_nxt;
            alu_op_q  <= alu_op_nxt;
            reg_in_q  <= reg_in_c;
            reg_out_q <= reg_out_c;
        end
    end

    assign bus.PCout    = ctrl_q.pc_out;
    assign bus.Zlowout  = ctrl_q.zlow_out;
    assign bus.Zhighout = ctrl_q.zhigh_out;
    assign bus.MDRout   = ctrl_q.mdr_out;
    assign bus.MARin    = ctrl_q.mar_in;
    assign bus.PCin     = ctrl_q.pc_in;
    assign bus.MDRin    = ctrl_q.mdr_in;
    assign bus.IRin     = ctrl_q.ir_in;
    assign bus.Yin      = ctrl_q.y_in;
    assign bus.Zin      = ctrl_q.z_in;
    assign bus.HIin     = ctrl_q.hi_in;
    assign bus.LOin     = ctrl_q.lo_in;
    assign bus.IncPC    = ctrl_q.inc_pc;
    assign bus.Read     = ctrl_q.read;
    assign bus.busy     = ctrl_q.busy;
    assign bus.done     = ctrl_q.done;
    assign bus.err      = ctrl_q.err;
    assign bus.alu_op   = alu_op_q;
    assign bus.reg_in   = reg_in_q;
    assign bus.reg_out  = reg_out_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench: a per-cycle expected trace is built from the instruction rules and compared every cycle.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        mem_ready;
        logic [31:0] ir;
        logic        pc_out, zlo, zhi, mdr_out, mar_in, pc_in, mdr_in, ir_in;
        logic        y_in, z_in, hi_in, lo_in, inc_pc, read;
        logic        busy, done, err;
        logic [4:0]  alu_op;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic exp_valid = 1'b0;
    rec_t exp_cur;
    rec_t plan[$];

    alu_op_sequencer_if #(.NUM_REGS(16), .OP_W(5)) bus ();

    alu_op_sequencer #(
        .NUM_REGS  (16),
        .REG_IDX_W (4),
        .OP_W      (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [53:0] exp_vec(input rec_t r);
        return {r.pc_out, r.zlo, r.zhi, r.mdr_out, r.mar_in, r.pc_in, r.mdr_in, r.ir_in,
                r.y_in, r.z_in, r.hi_in, r.lo_in, r.inc_pc, r.read,
                r.busy, r.done, r.err, r.alu_op, r.reg_in, r.reg_out};
    endfunction

    function automatic logic [53:0] act_vec();
        return {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.MARin, bus.PCin, bus.MDRin,
                bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin, bus.IncPC, bus.Read,
                bus.busy, bus.done, bus.err, bus.alu_op, bus.reg_in, bus.reg_out};
    endfunction

    // 0 binary, 1 unary, 2 wide (MUL/DIV), 3 illegal
    function automatic int cls_of(input logic [4:0] op);
        if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                       5'b01000, 5'b01001, 5'b01010, 5'b01011}) return 0;
        if (op inside {5'b10000, 5'b10001}) return 1;
        if (op inside {5'b01111, 5'b01110}) return 2;
        return 3;
    endfunction

    // Cycle with no expected activity: random data/handshake noise, no start.
    function automatic rec_t quiet_rec();
        rec_t r = '0;
        r.mem_ready = 1'($urandom());
        r.ir        = $urandom();
        return r;
    endfunction

    // Busy cycle: start noise must be ignored.
    function automatic rec_t busy_rec();
        rec_t r = quiet_rec();
        r.start = 1'($urandom());
        r.busy  = 1'b1;
        return r;
    endfunction

    function automatic rec_t reset_rec();
        rec_t r = quiet_rec();
        r.rst   = 1'b1;
        r.start = 1'($urandom());
        return r;
    endfunction

    // Expected per-cycle trace for one instruction with w memory wait cycles; optional reset at cycle abort_at.
    function automatic void push_instr(input logic [31:0] instr, input int w, input int abort_at);
        rec_t        tr[$];
        rec_t        r;
        logic [4:0]  op  = instr[31:27];
        logic [15:0] ra1 = 16'(1) << instr[26:23];
        logic [15:0] rb1 = 16'(1) << instr[22:19];
        logic [15:0] rc1 = 16'(1) << instr[18:15];
        int          cls = cls_of(op);

        r = quiet_rec(); r.start = 1'b1; tr.push_back(r);
        r = busy_rec(); r.pc_out = 1; r.mar_in = 1; r.inc_pc = 1; r.z_in = 1; tr.push_back(r);
        r = busy_rec(); r.zlo = 1; r.pc_in = 1; r.read = 1; r.mdr_in = 1;
        r.mem_ready = (w == 0); tr.push_back(r);
        for (int j = 1; j <= w; j++) begin
            r = busy_rec(); r.read = 1; r.mdr_in = 1; r.mem_ready = (j == w); tr.push_back(r);
        end
        r = busy_rec(); r.mdr_out = 1; r.ir_in = 1; r.ir = instr; tr.push_back(r);
        case (cls)
            0: begin
                r = busy_rec(); r.reg_out = rb1; r.y_in = 1; tr.push_back(r);
                r = busy_rec(); r.reg_out = rc1; r.alu_op = op; r.z_in = 1; tr.push_back(r);
                r = busy_rec(); r.zlo = 1; r.reg_in = ra1; tr.push_back(r);
            end
            1: begin
                r = busy_rec(); r.reg_out = rb1; r.alu_op = op; r.z_in = 1; tr.push_back(r);
                r = busy_rec(); r.zlo = 1; r.reg_in = ra1; tr.push_back(r);
            end
            2: begin
                r = busy_rec(); r.reg_out = ra1; r.y_in = 1; tr.push_back(r);
                r = busy_rec(); r.reg_out = rb1; r.alu_op = op; r.z_in = 1; tr.push_back(r);
                r = busy_rec(); r.zlo = 1; r.lo_in = 1; tr.push_back(r);
                r = busy_rec(); r.zhi = 1; r.hi_in = 1; tr.push_back(r);
            end
            default: begin
                r = busy_rec(); r.err = 1; tr.push_back(r);
            end
        endcase
        if (cls != 3) begin
            r = busy_rec(); r.done = 1; tr.push_back(r);
        end
        for (int i = 0; i < tr.size(); i++) begin
            if (abort_at >= 0 && i >= abort_at) break;
            plan.push_back(tr[i]);
        end
        if (abort_at >= 0) repeat (3) plan.push_back(reset_rec());
    endfunction

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 13))
            0:  return 5'b00011;
            1:  return 5'b00100;
            2:  return 5'b00101;
            3:  return 5'b00110;
            4:  return 5'b00111;
            5:  return 5'b01000;
            6:  return 5'b01001;
            7:  return 5'b01010;
            8:  return 5'b01011;
            9:  return 5'b01110;
            10: return 5'b01111;
            11: return 5'b10000;
            12: return 5'b10001;
            default: return 5'($urandom());
        endcase
    endfunction

    // Compare DUT outputs with the model on every cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_valid) check($sformatf("cycle%0d_outputs", cyc), 64'(act_vec()), 64'(exp_vec(exp_cur)));
        end
    end

    // Build plan, pin the model with hand-computed values, then replay it cycle by cycle.
    initial begin
        int b;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir        = '0;

        repeat (2) plan.push_back(reset_rec());

        b = plan.size(); push_instr(32'h82900000, 0, -1);
        check("pin_neg_t3", 64'({plan[b+4].reg_out, plan[b+4].alu_op, plan[b+4].z_in, plan[b+4].y_in}),
              64'({16'h0004, 5'b10000, 1'b1, 1'b0}));
        check("pin_neg_t4", 64'({plan[b+5].reg_in, plan[b+5].zlo}), 64'({16'h0020, 1'b1}));
        check("pin_neg_done", 64'({plan[b+5].done, plan[b+6].done}), 64'h1);

        b = plan.size(); push_instr(32'h2A920000, 0, -1);
        check("pin_and_t3", 64'({plan[b+4].reg_out, plan[b+4].y_in}), 64'({16'h0004, 1'b1}));
        check("pin_and_t4", 64'({plan[b+5].reg_out, plan[b+5].alu_op}), 64'({16'h0010, 5'b00101}));
        check("pin_and_t5", 64'(plan[b+6].reg_in), 64'h0020);
        check("pin_and_done", 64'(plan[b+7].done), 64'h1);

        b = plan.size(); push_instr(32'h79880000, 0, -1);
        check("pin_mul_t3_t4", 64'({plan[b+4].reg_out, plan[b+5].reg_out, plan[b+5].alu_op}),
              64'({16'h0008, 16'h0002, 5'b01111}));
        check("pin_mul_t5_t6", 64'({plan[b+6].lo_in, plan[b+6].zlo, plan[b+7].hi_in, plan[b+7].zhi}), 64'hF);
        check("pin_mul_done", 64'(plan[b+8].done), 64'h1);

        b = plan.size(); push_instr(32'h2A920000, 3, -1);
        check("pin_wait_t1w", 64'({plan[b+3].read, plan[b+3].mdr_in, plan[b+3].pc_in,
                                   plan[b+5].read, plan[b+5].mdr_in, plan[b+5].pc_in, plan[b+6].ir_in}),
              64'b1101101);

        b = plan.size(); push_instr(32'hF8000000, 0, -1);
        check("pin_ill", 64'({plan[b+4].err, plan[b+4].reg_in, plan[b+4].done, 32'(plan.size() - b)}),
              64'({1'b1, 16'h0, 1'b0, 32'd5}));

        push_instr(32'h2A920000, 0, 5);
        push_instr(32'h82900000, 0, -1);
        push_instr(32'h79880000, 4, 4);
        push_instr(32'h79880000, 2, -1);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] instr;
            int          w;
            int          ab;
            repeat ($urandom_range(0, 2)) plan.push_back(quiet_rec());
            instr = {rand_op(), 4'($urandom()), 4'($urandom()), 4'($urandom()), 15'($urandom())};
            w     = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            ab    = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : -1;
            push_instr(instr, w, ab);
        end
        plan.push_back(quiet_rec());

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            rst           = plan[i].rst;
            bus.start     = plan[i].start;
            bus.mem_ready = plan[i].mem_ready;
            bus.ir        = plan[i].ir;
            exp_cur       = plan[i];
            cyc           = i;
            exp_valid     = 1'b1;
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
